// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder controller.
// The requester (master) drives start and the operands; the adder (slave)
// returns busy/done status together with the registered result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds a single one-bit full adder LSB-first
// for WIDTH cycles, keeping the carry in a flip-flop between bits, and
// publishes {cout,sum} with a one-cycle done pulse. A new request can be
// accepted in the DONE cycle, giving one result every WIDTH+1 cycles.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] op_a_sh;
  logic [WIDTH-1:0] op_b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_c;
  logic             load;
  logic             last_bit;
  logic             busy_c;
  logic             done_c;

  // The one-bit datapath shared by every bit position.
  full_adder u_fa (
    .a   (op_a_sh[0]),
    .b   (op_b_sh[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  // Result register contents after this edge's sum bit enters at the MSB;
  // a one-bit adder has nothing to shift, so the new bit is the whole result.
  generate
    if (WIDTH == 1) begin : g_res_one
      assign res_next = fa_s;
    end else begin : g_res_wide
      assign res_next = {fa_s, res_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // State register; reset dominates any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture, per-bit shifting, and result publication on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_sh <= '0;
      op_b_sh <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (load) begin
      op_a_sh <= bus.a;
      op_b_sh <= bus.b;
      res_sh  <= '0;
      carry_q <= bus.cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      op_a_sh <= op_a_sh >> 1;
      op_b_sh <= op_b_sh >> 1;
      res_sh  <= res_next;
      carry_q <= fa_c;
      cnt_q   <= cnt_q + CW'(1);
      if (last_bit) begin
        sum_q  <= res_next;
        cout_q <= fa_c;
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// One-bit full adder used as the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;
  int done_seen = 0;
  string scen = "reset";

  // Reference model: cycles left before the pending result appears, plus
  // the arithmetic result a+b+cin computed when the request is accepted.
  int           remaining = 0;
  logic [W:0]   pending = '0;
  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;
  logic         exp_done = 1'b0;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got === want) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs, advance the model one edge, compare all outputs.
  task automatic applyStimulus(input logic r, input logic s,
                               input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic ci);
    rst       = r;
    bus.start = s;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
    @(posedge clk);
    if (r) begin
      remaining = 0;
      exp_done  = 1'b0;
      exp_sum   = '0;
      exp_cout  = 1'b0;
    end else if (remaining > 0) begin
      remaining--;
      exp_done = (remaining == 0);
      if (remaining == 0) begin
        {exp_cout, exp_sum} = pending;
      end
    end else begin
      exp_done = 1'b0;
      if (s) begin
        remaining = W;
        pending   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
      end
    end
    @(negedge clk);
    if (bus.done === 1'b1) done_seen++;
    checkOutput({scen, "_busy"}, 32'(bus.busy), 32'(remaining > 0));
    checkOutput({scen, "_done"}, 32'(bus.done), 32'(exp_done));
    checkOutput({scen, "_sum"},  32'(bus.sum),  32'(exp_sum));
    checkOutput({scen, "_cout"}, 32'(bus.cout), 32'(exp_cout));
  endtask

  // Accept one request, then run W cycles with junk operands and start low.
  task automatic runOp(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci);
    applyStimulus(1'b0, 1'b1, av, bv, ci);
    for (int i = 0; i < W; i++) begin
      applyStimulus(1'b0, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

    // Reset, with start also high on one edge: reset must win.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h12, 8'h34, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

    scen = "basic";
    runOp(8'h5A, 8'h3C, 1'b0);
    checkOutput("basic_sum_const", 32'(bus.sum), 32'h96);
    checkOutput("basic_cout_const", 32'(bus.cout), 32'h0);
    checkOutput("basic_done_const", 32'(bus.done), 32'h1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("basic_hold_sum", 32'(bus.sum), 32'h96);

    scen = "ripple";
    runOp(8'hFF, 8'h01, 1'b0);
    checkOutput("ripple_sum_const", 32'(bus.sum), 32'h00);
    checkOutput("ripple_cout_const", 32'(bus.cout), 32'h1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

    scen = "satur";
    runOp(8'hFF, 8'hFF, 1'b1);
    checkOutput("satur_sum_const", 32'(bus.sum), 32'hFF);
    checkOutput("satur_cout_const", 32'(bus.cout), 32'h1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

    scen = "busystart";
    done_seen = 0;
    applyStimulus(1'b0, 1'b1, 8'h10, 8'h20, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hAA, 8'h55, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("busystart_sum_const", 32'(bus.sum), 32'h30);
    checkOutput("busystart_cout_const", 32'(bus.cout), 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("busystart_done_count", 32'(done_seen), 32'd1);

    scen = "midreset";
    done_seen = 0;
    applyStimulus(1'b0, 1'b1, 8'h0F, 8'h0F, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("midreset_busy0", 32'(bus.busy), 32'h0);
    checkOutput("midreset_sum0", 32'(bus.sum), 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("midreset_no_done", 32'(done_seen), 32'd0);
    runOp(8'h01, 8'h02, 1'b0);
    checkOutput("midreset_fresh_sum", 32'(bus.sum), 32'h03);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

    scen = "b2b";
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    for (int i = 0; i < W; i++) applyStimulus(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    checkOutput("b2b_first_done", 32'(bus.done), 32'h1);
    checkOutput("b2b_first_sum", 32'({bus.cout, bus.sum}), 32'h002);
    for (int i = 0; i <= W; i++) applyStimulus(1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
    checkOutput("b2b_second_done", 32'(bus.done), 32'h1);
    checkOutput("b2b_second_sum", 32'({bus.cout, bus.sum}), 32'h100);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

    scen = "random";
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 2) == 0),
                    W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
